hazard_unit_sb: RTL and testbench
=================================

// Module: hazard_unit_sb
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core: EX-stage operand forwarding for
//  NUM_SRC source ports, load-use interlock, scoreboard interlock for long-latency ops (mul/div/
//  multi-cycle load) and a timed flush sequencer for EX-resolved redirects. Sits beside the
//  ID/EX/MEM/WB pipeline registers; drives their stall/flush enables and the EX operand muxes.
// PARAMETERS
//  NUM_SRC       2   source operands per instruction (1..3)
//  REG_ADDR_W    5   register-address width; register file depth = 2**REG_ADDR_W
//  FLUSH_CYCLES  2   cycles flush_d/flush_e stay high after a redirect (1..15)
// PORTS
//  clk                 in   1                   core clock
//  reset               in   1                   asynchronous, active-high
//  d_valid             in   1                   valid instruction in ID
//  d_rs_addr           in   NUM_SRC*REG_ADDR_W  ID source regs, src i at [i*REG_ADDR_W +: REG_ADDR_W]
//  d_lo_dest           in   REG_ADDR_W          ID dest reg (checked only when d_lo_issue=1)
//  d_lo_issue          in   1                   ID instruction is a long-latency op
//  e_rs_addr           in   NUM_SRC*REG_ADDR_W  EX source regs, same packing
//  e_reg_write_enable  in   1                   EX instruction writes a register
//  e_dest_reg          in   REG_ADDR_W          EX dest reg
//  e_is_load           in   1                   EX instruction is a single-cycle-latency load
//  e_redirect          in   1                   EX resolved taken branch / mispredict
//  m_reg_write_enable  in   1 ; m_dest_reg in REG_ADDR_W   MEM-stage writer
//  w_reg_write_enable  in   1 ; w_dest_reg in REG_ADDR_W   WB-stage writer
//  lo_wb_valid         in   1                   long-latency unit writing back this cycle
//  lo_wb_dest          in   REG_ADDR_W          its dest reg
//  forward_sel         out  2*NUM_SRC           per src: 00 regfile, 10 from MEM, 01 from WB
//  stall_f, stall_d    out  1                   hold PC / IF-ID register
//  flush_d, flush_e    out  1                   bubble IF-ID / ID-EX register
//  busy_vec            out  2**REG_ADDR_W       scoreboard state (debug)
// BEHAVIOUR
//  - Reset: busy_vec=0, flush counter=0, all outputs 0; forward_sel forced 00 while reset=1.
//  - Forwarding (comb): per src i, MEM match (we, dest!=0, dest==rs) -> 10, else WB match -> 01,
//    else 00. MEM beats WB when both match. Register 0 never forwarded.
//  - Load-use (comb): e_is_load & e_reg_write_enable & e_dest_reg!=0 & d_valid & e_dest_reg equals
//    any d_rs -> stall_f=stall_d=1, flush_e=1 for that cycle (one bubble).
//  - Scoreboard (registered): busy[d_lo_dest] set at clk edge when d_valid & d_lo_issue & !stall_d
//    & !flush_d & d_lo_dest!=0; busy[lo_wb_dest] cleared when lo_wb_valid. Same reg set+clear in
//    one cycle -> set wins. busy[0] always 0. Clear visible to ID on the following cycle.
//  - Scoreboard stall (comb): d_valid & (any d_rs busy (RAW) | d_lo_issue & busy[d_lo_dest] (WAW))
//    -> stall_f=stall_d=1, flush_e=1.
//  - Flush FSM: IDLE -> FLUSH on e_redirect, counter loaded with FLUSH_CYCLES-1; flush_d=flush_e=1
//    in the redirect cycle and while counter>0 in FLUSH; counter decrements, FLUSH -> IDLE at 0.
//    e_redirect while in FLUSH reloads counter. Reset mid-flush -> IDLE, flushes drop at once.
//  - Priority: flush over stall; while flush_d=1, stall_f=stall_d=0 and scoreboard set suppressed.
//  - Stall and flush outputs are combinational from inputs plus registered busy/counter; no
//    input-to-output path crosses a clock edge except via busy_vec and the flush counter.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_cycles[31:0], flush_cycles[31:0]; each is a
//  saturating counter incremented every cycle stall_d / flush_d is 1, cleared by reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 MEM x5 write, WB x5 write, e_rs0=5 -> forward_sel[1:0]=10; drop MEM write -> 01; rs0=0 -> 00.
//  2 EX load x7, ID d_rs1=7 d_valid=1 -> stall_f/stall_d/flush_e=1 one cycle, 0 next cycle.
//  3 Issue lo to x9; ID rs0=9 next cycle -> stall until cycle after lo_wb_valid/lo_wb_dest=9.
//  4 lo_wb_valid x9 same cycle as new issue to x9 -> busy_vec[9] stays 1.
//  5 e_redirect at t0, FLUSH_CYCLES=2 -> flush_d=flush_e=1 at t0,t1, 0 at t2; redirect at t1 extends.
//  6 reset asserted mid-flush with busy bits set -> all outputs 0 and busy_vec=0 asynchronously.

Source files
------------

// File: rtl/hazard_unit_sb_if.sv
// hazard_unit_sb_if: pipeline-side signals of the hazard controller (ID/EX/MEM/WB taps and control outputs)
interface hazard_unit_sb_if #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5
);
  logic                          d_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] d_rs_addr;
  logic [REG_ADDR_W-1:0]         d_lo_dest;
  logic                          d_lo_issue;
  logic [NUM_SRC*REG_ADDR_W-1:0] e_rs_addr;
  logic                          e_reg_write_enable;
  logic [REG_ADDR_W-1:0]         e_dest_reg;
  logic                          e_is_load;
  logic                          e_redirect;
  logic                          m_reg_write_enable;
  logic [REG_ADDR_W-1:0]         m_dest_reg;
  logic                          w_reg_write_enable;
  logic [REG_ADDR_W-1:0]         w_dest_reg;
  logic                          lo_wb_valid;
  logic [REG_ADDR_W-1:0]         lo_wb_dest;
  logic [2*NUM_SRC-1:0]          forward_sel;
  logic                          stall_f;
  logic                          stall_d;
  logic                          flush_d;
  logic                          flush_e;
  logic [2**REG_ADDR_W-1:0]      busy_vec;
  modport master (
    output d_valid, d_rs_addr, d_lo_dest, d_lo_issue, e_rs_addr, e_reg_write_enable, e_dest_reg,
           e_is_load, e_redirect, m_reg_write_enable, m_dest_reg, w_reg_write_enable, w_dest_reg,
           lo_wb_valid, lo_wb_dest,
    input  forward_sel, stall_f, stall_d, flush_d, flush_e, busy_vec
  );
  modport slave (
    input  d_valid, d_rs_addr, d_lo_dest, d_lo_issue, e_rs_addr, e_reg_write_enable, e_dest_reg,
           e_is_load, e_redirect, m_reg_write_enable, m_dest_reg, w_reg_write_enable, w_dest_reg,
           lo_wb_valid, lo_wb_dest,
    output forward_sel, stall_f, stall_d, flush_d, flush_e, busy_vec
  );
endinterface

// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: forwarding, load-use and scoreboard interlocks plus timed redirect flush
// Define HAZARD_STATS_EN to add saturating stall_cycles/flush_cycles counters.
module hazard_unit_sb #(
  parameter int NUM_SRC      = 2,
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_sb_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_cycles
`endif
);
  localparam int DEPTH = 2**REG_ADDR_W;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [DEPTH-1:0]      busy, set_mask, clr_mask;
  logic                  load_use, sb_stall, hazard, flush, stall;
  function automatic logic hit(input logic we, input logic [REG_ADDR_W-1:0] dest, rs);
    return we && |dest && dest == rs;
  endfunction
  always_comb begin
    hz.forward_sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      hz.forward_sel[2*i +: 2] = reset ? 2'b00 :
        hit(hz.m_reg_write_enable, hz.m_dest_reg, hz.e_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]) ? 2'b10 :
        hit(hz.w_reg_write_enable, hz.w_dest_reg, hz.e_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]) ? 2'b01 : 2'b00;
  end
  always_comb begin
    load_use = 1'b0;
    sb_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      load_use = load_use | (hz.d_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == hz.e_dest_reg);
      sb_stall = sb_stall | busy[hz.d_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]];
    end
    load_use = load_use && hz.e_is_load && hz.e_reg_write_enable && |hz.e_dest_reg && hz.d_valid;
    sb_stall = hz.d_valid && (sb_stall || (hz.d_lo_issue && busy[hz.d_lo_dest]));
  end
  // reset gates every combinational output so the pipeline sees a clean idle immediately
  assign flush       = !reset && (hz.e_redirect || (state == FLUSH && cnt != 4'd0));
  assign hazard      = !reset && (load_use || sb_stall);
  assign stall       = hazard && !flush;
  assign hz.flush_d  = flush;
  assign hz.flush_e  = flush || hazard;
  assign hz.stall_f  = stall;
  assign hz.stall_d  = stall;
  assign hz.busy_vec = busy;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (hz.e_redirect) begin
      cnt_n   = 4'(FLUSH_CYCLES - 1);
      state_n = FLUSH_CYCLES > 1 ? FLUSH : IDLE;
    end else if (state == FLUSH) begin
      cnt_n   = cnt > 4'd1 ? cnt - 4'd1 : 4'd0;
      state_n = cnt > 4'd1 ? FLUSH : IDLE;
    end
  end
  assign set_mask = (hz.d_valid && hz.d_lo_issue && !stall && !flush && |hz.d_lo_dest) ?
                    DEPTH'(1) << hz.d_lo_dest : '0;
  assign clr_mask = hz.lo_wb_valid ? DEPTH'(1) << hz.lo_wb_dest : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= ((busy & ~clr_mask) | set_mask) & ~DEPTH'(1);
    end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall && !(&stall_cycles));
      flush_cycles <= flush_cycles + 32'(flush && !(&flush_cycles));
    end
`endif
endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb_hazard_unit_sb: scoreboard-driven directed checks of forwarding, interlocks, flush and reset
module tb_hazard_unit_sb;
  typedef logic [39:0] exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  exp_t exp_q[$];
  exp_t got, ex;
  hazard_unit_sb_if #(.NUM_SRC(2), .REG_ADDR_W(5)) h();
`ifdef HAZARD_STATS_EN
  logic [31:0] sc, fc;
`endif
  hazard_unit_sb #(.NUM_SRC(2), .REG_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .hz(h)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc), .flush_cycles(fc)
`endif
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [3:0] fs, input logic sf, sd, fd, fe, input logic [31:0] b);
    return {fs, sf, sd, fd, fe, b};
  endfunction
  function automatic exp_t obs();
    return {h.forward_sel, h.stall_f, h.stall_d, h.flush_d, h.flush_e, h.busy_vec};
  endfunction
  task automatic idle();
    h.d_valid = 0; h.d_rs_addr = '0; h.d_lo_dest = '0; h.d_lo_issue = 0;
    h.e_rs_addr = '0; h.e_reg_write_enable = 0; h.e_dest_reg = '0; h.e_is_load = 0; h.e_redirect = 0;
    h.m_reg_write_enable = 0; h.m_dest_reg = '0; h.w_reg_write_enable = 0; h.w_dest_reg = '0;
    h.lo_wb_valid = 0; h.lo_wb_dest = '0;
  endtask
  task automatic test_reset();
    idle();
    h.m_reg_write_enable = 1; h.m_dest_reg = 5; h.e_rs_addr = {5'd5, 5'd5}; h.e_redirect = 1;
    h.d_valid = 1; h.e_is_load = 1; h.e_reg_write_enable = 1; h.e_dest_reg = 5; h.d_rs_addr = {5'd0, 5'd5};
    exp_q.push_back(mk(4'b0000, 0, 0, 0, 0, 32'h0));
    #2;
    got = obs(); ex = exp_q.pop_front(); total++;
    if (got !== ex) $display("FAIL reset got=%h exp=%h", got, ex); else passed++;
    @(negedge clk); idle(); reset = 0;
  endtask
  task automatic test_forwarding();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; idle();
      h.m_reg_write_enable = (k != 1); h.m_dest_reg = (k == 3) ? 5'd0 : 5'd5;
      h.w_reg_write_enable = 1; h.w_dest_reg = 5;
      h.e_rs_addr = (k == 0) ? {5'd3, 5'd5} : (k == 1) ? {5'd5, 5'd5} : (k == 2) ? {5'd5, 5'd0} : {5'd5, 5'd5};
      exp_q.push_back(mk(k == 0 ? 4'b0010 : k == 1 ? 4'b0101 : k == 2 ? 4'b1000 : 4'b0101, 0, 0, 0, 0, 32'h0));
      @(negedge clk);
      got = obs(); ex = exp_q.pop_front(); total++;
      if (got !== ex) $display("FAIL forward%0d got=%h exp=%h", k, got, ex); else passed++;
    end
  endtask
  task automatic test_load_use();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; idle();
      h.d_valid = (k != 3); h.e_reg_write_enable = 1;
      h.e_is_load = (k != 1); h.e_dest_reg = (k == 2) ? 5'd0 : 5'd7;
      h.d_rs_addr = (k == 2) ? {5'd0, 5'd0} : {5'd7, 5'd1};
      exp_q.push_back(k == 0 ? mk(4'b0, 1, 1, 0, 1, 32'h0) : mk(4'b0, 0, 0, 0, 0, 32'h0));
      @(negedge clk);
      got = obs(); ex = exp_q.pop_front(); total++;
      if (got !== ex) $display("FAIL load_use%0d got=%h exp=%h", k, got, ex); else passed++;
    end
  endtask
  task automatic test_scoreboard();
    logic [7:0] st = 8'b0100_1110;
    logic [31:0] bv [8] = '{32'h0, 32'h200, 32'h200, 32'h200, 32'h0, 32'h0, 32'h200, 32'h200};
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1; idle();
      h.d_valid = (k != 7);
      h.d_lo_issue = (k == 0 || k == 5 || k == 6); h.d_lo_dest = 9;
      h.d_rs_addr = (k >= 1 && k <= 4) ? {5'd0, 5'd9} : '0;
      h.lo_wb_valid = (k == 3 || k == 7); h.lo_wb_dest = 9;
      exp_q.push_back(mk(4'b0, st[k], st[k], 0, st[k], bv[k]));
      @(negedge clk);
      got = obs(); ex = exp_q.pop_front(); total++;
      if (got !== ex) $display("FAIL scoreboard%0d got=%h exp=%h", k, got, ex); else passed++;
    end
  endtask
  task automatic test_set_clear();
    logic [31:0] bv [5] = '{32'h0, 32'h200, 32'h200, 32'h0, 32'h0};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; idle();
      h.d_valid = (k == 0 || k == 3); h.d_lo_issue = (k == 0 || k == 3);
      h.d_lo_dest = (k == 3) ? 5'd0 : 5'd9;
      h.lo_wb_valid = (k == 0 || k == 2); h.lo_wb_dest = 9;
      exp_q.push_back(mk(4'b0, 0, 0, 0, 0, bv[k]));
      @(negedge clk);
      got = obs(); ex = exp_q.pop_front(); total++;
      if (got !== ex) $display("FAIL set_clear%0d got=%h exp=%h", k, got, ex); else passed++;
    end
  endtask
  task automatic test_flush();
    logic [6:0] fl = 7'b0111011;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1; idle();
      h.e_redirect = (k == 0 || k == 3 || k == 4);
      if (k == 0) begin
        h.d_valid = 1; h.d_lo_issue = 1; h.d_lo_dest = 12; h.d_rs_addr = {5'd7, 5'd0};
        h.e_is_load = 1; h.e_reg_write_enable = 1; h.e_dest_reg = 7;
      end
      exp_q.push_back(mk(4'b0, 0, 0, fl[k], fl[k], 32'h0));
      @(negedge clk);
      got = obs(); ex = exp_q.pop_front(); total++;
      if (got !== ex) $display("FAIL flush%0d got=%h exp=%h", k, got, ex); else passed++;
    end
  endtask
  task automatic test_reset_mid_flush();
    @(posedge clk); #1; idle();
    h.d_valid = 1; h.d_lo_issue = 1; h.d_lo_dest = 9;
    @(posedge clk); #1; idle();
    h.e_redirect = 1; h.d_valid = 1; h.d_lo_issue = 1; h.d_lo_dest = 10;
    exp_q.push_back(mk(4'b0, 0, 0, 1, 1, 32'h200));
    @(negedge clk);
    got = obs(); ex = exp_q.pop_front(); total++;
    if (got !== ex) $display("FAIL pre_reset got=%h exp=%h", got, ex); else passed++;
    @(posedge clk); #1; idle();
    h.e_redirect = 1; h.m_reg_write_enable = 1; h.m_dest_reg = 5; h.e_rs_addr = {5'd5, 5'd5};
    #1 reset = 1;
    exp_q.push_back(mk(4'b0, 0, 0, 0, 0, 32'h0));
    #1;
    got = obs(); ex = exp_q.pop_front(); total++;
    if (got !== ex) $display("FAIL async_reset got=%h exp=%h", got, ex); else passed++;
    @(negedge clk); idle(); reset = 0;
    @(posedge clk); #1; idle();
    exp_q.push_back(mk(4'b0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    got = obs(); ex = exp_q.pop_front(); total++;
    if (got !== ex) $display("FAIL post_reset got=%h exp=%h", got, ex); else passed++;
  endtask
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_set_clear();
    test_flush();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
